// File: rtl/blk_c24d3f.sv
// Avalon-ST ready-latency adapter for the 10G MAC RX path: absorbs beats from a
// latency-L (or unstoppable) source into a show-ahead FIFO, presents them at latency 0.
module blk_c24d3f #(
  parameter int DATA_WIDTH       = 72,
  parameter int IN_READY_LATENCY = 2,
  parameter int IN_HAS_READY     = 1,
  parameter int DEPTH            = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clear_stats
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int RDY_MAX = DEPTH - IN_READY_LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop, space, wr_en, drop;

  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];
  assign fill_level = count;

  // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign pop   = out_valid && out_ready;
  assign space = (count < CW'(DEPTH)) || pop;
  assign wr_en = in_valid && space;
  assign drop  = in_valid && !space;

  // threshold leaves room for the L beats still in flight after deassertion
  if (IN_HAS_READY != 0) begin : g_rdy
    assign in_ready = (count <= CW'(RDY_MAX));
  end else begin : g_nordy
    assign in_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // clear takes priority over a drop landing in the same cycle
      if (clear_stats) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // with a ready-honouring source a full-FIFO arrival means the source broke its latency contract
  always_ff @(posedge clk) begin
    if (!reset && IN_HAS_READY != 0)
      assert (!drop) else $error("blk_c24d3f: beat arrived to full FIFO, source violated ready latency");
  end
endmodule

// File: tb/tb_blk_c24d3f.sv
// Bench: one ready-latency instance (L=2, DEPTH=8) and one drop-mode instance (DEPTH=4),
// both compared against queue-based models of the FIFO behaviour.
module tb_blk_c24d3f;
  localparam int DW = 72, LA = 2, DA = 8, DB = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] a_in_data = '0, a_out_data, b_in_data = '0, b_out_data;
  logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_overflow, a_clear = 1'b0;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_overflow, b_clear = 1'b0;
  logic [3:0] a_fill;
  logic [2:0] b_fill;
  logic [15:0] a_drops, b_drops;

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] qa[$], qb[$];
  int dra = 0, drb = 0;
  bit ova = 0, ovb = 0;
  bit rh[$];

  always #5 clk = ~clk;

  blk_c24d3f #(.DATA_WIDTH(DW), .IN_READY_LATENCY(LA), .IN_HAS_READY(1), .DEPTH(DA)) u_dut (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .fill_level(a_fill),
    .overflow(a_overflow), .drop_count(a_drops), .clear_stats(a_clear));

  blk_c24d3f #(.DATA_WIDTH(DW), .IN_READY_LATENCY(0), .IN_HAS_READY(0), .DEPTH(DB)) u_drop (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .fill_level(b_fill),
    .overflow(b_overflow), .drop_count(b_drops), .clear_stats(b_clear));

  function automatic logic [DW-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // one clock: models advance on the inputs present at the edge; outputs sampled 1ns later
  task automatic tick();
    bit popa, popb, spa, spb;
    @(posedge clk);
    if (reset) begin
      qa.delete(); qb.delete(); dra = 0; drb = 0; ova = 0; ovb = 0;
    end else begin
      popa = (qa.size() != 0) && a_out_ready;
      spa  = (qa.size() < DA) || popa;
      if (popa) void'(qa.pop_front());
      if (a_in_valid && spa) qa.push_back(a_in_data);
      if (a_clear) begin dra = 0; ova = 0; end
      else if (a_in_valid && !spa) begin ova = 1; if (dra < 65535) dra++; end
      popb = (qb.size() != 0) && b_out_ready;
      spb  = (qb.size() < DB) || popb;
      if (popb) void'(qb.pop_front());
      if (b_in_valid && spb) qb.push_back(b_in_data);
      if (b_clear) begin drb = 0; ovb = 0; end
      else if (b_in_valid && !spb) begin ovb = 1; if (drb < 65535) drb++; end
    end
    #1;
    rh.push_front(a_in_ready);
    if (rh.size() > LA + 1) void'(rh.pop_back());
  endtask

  // rh[0] is this cycle's in_ready; a beat may be presented now only if ready was high LA cycles ago
  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    rh.delete();
    repeat (LA) rh.push_back(1'b0);
    rh.push_front(a_in_ready);
  endtask

  task automatic test_reset();
    a_in_valid = 1'b1; b_in_valid = 1'b1;
    do_reset(3);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b exp 0", a_out_valid); end
    n_checks++; if (a_fill !== 4'd0) begin n_fail++; $display("FAIL rst_a_fill got %0d exp 0", a_fill); end
    n_checks++; if (a_overflow !== 1'b0 || a_drops !== 16'd0) begin n_fail++; $display("FAIL rst_a_stats got %b/%0d exp 0/0", a_overflow, a_drops); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready got %b exp 1", a_in_ready); end
    n_checks++; if (b_out_valid !== 1'b0 || b_fill !== 3'd0) begin n_fail++; $display("FAIL rst_b_state got %b/%0d exp 0/0", b_out_valid, b_fill); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready got %b exp 1", b_in_ready); end
  endtask

  task automatic test_streaming();
    int sent = 0, rcv = 0, first = -1;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && rcv < 100; cyc++) begin
      a_in_valid = (sent < 100) && rh[LA];
      a_in_data  = {8'h5A, 64'(sent)};
      tick();
      if (a_in_valid) begin
        if (sent == 0) begin
          n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== {8'h5A, 64'd0}) begin n_fail++; $display("FAIL stream_first got %b/%h exp 1/%h", a_out_valid, a_out_data, {8'h5A, 64'd0}); end
        end
        sent++;
      end
      if (a_out_valid) begin
        n_checks++; if (a_out_data !== {8'h5A, 64'(rcv)}) begin n_fail++; $display("FAIL stream_data got %h exp %h", a_out_data, {8'h5A, 64'(rcv)}); end
        if (first < 0) first = cyc;
        rcv++;
      end else if (first >= 0 && rcv < 100) begin
        n_checks++; n_fail++; $display("FAIL stream_gap got out_valid 0 exp 1 at beat %0d", rcv);
      end
    end
    a_in_valid = 1'b0;
    tick();
    n_checks++; if (rcv !== 100) begin n_fail++; $display("FAIL stream_count got %0d exp 100", rcv); end
    n_checks++; if (a_drops !== 16'd0 || a_fill !== 4'd0) begin n_fail++; $display("FAIL stream_end got drops %0d fill %0d exp 0/0", a_drops, a_fill); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      a_in_valid = rh[LA];
      a_in_data  = {8'hB0, 64'(sent)};
      tick();
      if (a_in_valid) sent++;
      n_checks++; if (a_in_ready !== (qa.size() <= DA - LA - 1)) begin n_fail++; $display("FAIL bp_ready got %b exp %b at fill %0d", a_in_ready, (qa.size() <= DA - LA - 1), qa.size()); end
    end
    a_in_valid = 1'b0;
    n_checks++; if (a_fill !== 4'd8 || sent != 8) begin n_fail++; $display("FAIL bp_fill got %0d sent %0d exp 8/8", a_fill, sent); end
    n_checks++; if (a_drops !== 16'd0 || a_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_loss got %0d/%b exp 0/0", a_drops, a_overflow); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== {8'hB0, 64'(i)}) begin n_fail++; $display("FAIL bp_drain got %b/%h exp 1/%h", a_out_valid, a_out_data, {8'hB0, 64'(i)}); end
      n_checks++; if (a_in_ready !== (8 - i <= 5)) begin n_fail++; $display("FAIL bp_ready_rise got %b exp %b at fill %0d", a_in_ready, (8 - i <= 5), 8 - i); end
      tick();
    end
    n_checks++; if (a_out_valid !== 1'b0 || a_fill !== 4'd0) begin n_fail++; $display("FAIL bp_empty got %b/%0d exp 0/0", a_out_valid, a_fill); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_out_ready = ($urandom % 4) != 0;
      a_in_valid  = rh[LA] && (($urandom % 4) != 0);
      a_in_data   = rnd72();
      b_out_ready = ($urandom % 3) == 0;
      b_in_valid  = ($urandom % 2) != 0;
      b_in_data   = rnd72();
      tick();
      n_checks++; if (a_out_valid !== (qa.size() != 0) || a_fill !== 4'(qa.size())) begin n_fail++; $display("FAIL rnd_a_occ got %b/%0d exp fill %0d", a_out_valid, a_fill, qa.size()); end
      if (qa.size() != 0) begin
        n_checks++; if (a_out_data !== qa[0]) begin n_fail++; $display("FAIL rnd_a_data got %h exp %h", a_out_data, qa[0]); end
      end
      n_checks++; if (b_out_valid !== (qb.size() != 0) || b_fill !== 3'(qb.size())) begin n_fail++; $display("FAIL rnd_b_occ got %b/%0d exp fill %0d", b_out_valid, b_fill, qb.size()); end
      if (qb.size() != 0) begin
        n_checks++; if (b_out_data !== qb[0]) begin n_fail++; $display("FAIL rnd_b_data got %h exp %h", b_out_data, qb[0]); end
      end
      n_checks++; if (b_drops !== 16'(drb) || b_overflow !== ovb || a_drops !== 16'd0) begin n_fail++; $display("FAIL rnd_stats got b %0d/%b a %0d exp b %0d/%b a 0", b_drops, b_overflow, a_drops, drb, ovb); end
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (DA + 1) tick();
  endtask

  task automatic test_drop_mode();
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    b_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1; b_in_data = {8'hD0, 64'(i)};
      tick();
      n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready got %b exp 1", b_in_ready); end
    end
    b_in_valid = 1'b0;
    n_checks++; if (b_fill !== 3'd4) begin n_fail++; $display("FAIL drop_fill got %0d exp 4", b_fill); end
    n_checks++; if (b_overflow !== 1'b1 || b_drops !== 16'd6) begin n_fail++; $display("FAIL drop_stats got %b/%0d exp 1/6", b_overflow, b_drops); end
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_out_data !== {8'hD0, 64'(i)}) begin n_fail++; $display("FAIL drop_order got %h exp %h", b_out_data, {8'hD0, 64'(i)}); end
      tick();
    end
  endtask

  task automatic test_full_pop();
    b_clear = 1'b1; b_out_ready = 1'b0; tick(); b_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_data = {8'hF0, 64'(i)}; tick();
    end
    b_in_data = {8'hF0, 64'd4}; b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    n_checks++; if (b_fill !== 3'd4 || b_drops !== 16'd0 || b_overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop got fill %0d drops %0d ovf %b exp 4/0/0", b_fill, b_drops, b_overflow); end
    n_checks++; if (b_out_data !== {8'hF0, 64'd1}) begin n_fail++; $display("FAIL fullpop_head got %h exp %h", b_out_data, {8'hF0, 64'd1}); end
    b_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (b_out_data !== {8'hF0, 64'(i)}) begin n_fail++; $display("FAIL fullpop_order got %h exp %h", b_out_data, {8'hF0, 64'(i)}); end
      tick();
    end
  endtask

  task automatic test_saturation();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = {8'h77, 64'd0};
    repeat (70004) tick();
    n_checks++; if (b_drops !== 16'hFFFF || b_overflow !== 1'b1) begin n_fail++; $display("FAIL sat got %h/%b exp ffff/1", b_drops, b_overflow); end
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    n_checks++; if (b_drops !== 16'd0 || b_overflow !== 1'b0) begin n_fail++; $display("FAIL clear_wins got %0d/%b exp 0/0", b_drops, b_overflow); end
    tick();
    b_in_valid = 1'b0;
    n_checks++; if (b_drops !== 16'd1 || b_overflow !== 1'b1) begin n_fail++; $display("FAIL post_clear got %0d/%b exp 1/1", b_drops, b_overflow); end
  endtask

  task automatic test_reset_mid();
    int sent = 0, rcv = 0;
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && sent < 5; cyc++) begin
      a_in_valid = rh[LA]; a_in_data = {8'hC0, 64'(sent)};
      tick();
      if (a_in_valid) sent++;
    end
    a_in_valid = 1'b0;
    n_checks++; if (a_fill !== 4'd5) begin n_fail++; $display("FAIL mid_prefill got %0d exp 5", a_fill); end
    a_in_valid = 1'b1; a_in_data = {8'hEE, 64'hDEAD};
    do_reset(1);
    a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0 || a_fill !== 4'd0) begin n_fail++; $display("FAIL mid_flush got %b/%0d exp 0/0", a_out_valid, a_fill); end
    sent = 0; a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && rcv < 3; cyc++) begin
      a_in_valid = (sent < 3) && rh[LA]; a_in_data = {8'hE0, 64'(sent)};
      tick();
      if (a_in_valid) sent++;
      if (a_out_valid) begin
        n_checks++; if (a_out_data !== {8'hE0, 64'(rcv)}) begin n_fail++; $display("FAIL mid_stale got %h exp %h", a_out_data, {8'hE0, 64'(rcv)}); end
        rcv++;
      end
    end
    a_in_valid = 1'b0;
    n_checks++; if (rcv != 3) begin n_fail++; $display("FAIL mid_count got %0d exp 3", rcv); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_drop_mode();
    test_full_pop();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1);
  end
endmodule
